// File: rtl/serial_adder_pkg.sv
// -----------------------------------------------------------------------------
// serial_adder_pkg
// Shared definitions for the bit-serial adder:
//   - FSM state encodings (ST_IDLE / ST_RUN / ST_DONE) and the state_t enum
//   - legal WIDTH limits (WIDTH_MIN .. WIDTH_MAX)
// No ports (package).
// -----------------------------------------------------------------------------
package serial_adder_pkg;

    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 32;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        STATE_IDLE = ST_IDLE,
        STATE_RUN  = ST_RUN,
        STATE_DONE = ST_DONE
    } state_t;

endpackage

// File: rtl/serial_adder_full_adder.sv
// -----------------------------------------------------------------------------
// FULL_ADDER
// Purely combinational 1-bit full adder cell.
// Ports:
//   A, B  in  operand bits
//   Ci    in  carry-in
//   S     out sum bit
//   Co    out carry-out
// -----------------------------------------------------------------------------
module FULL_ADDER (
    input  logic A,
    input  logic B,
    input  logic Ci,
    output logic S,
    output logic Co
);

    assign S  = A ^ B ^ Ci;
    assign Co = (A & B) | (Ci & (A ^ B));

endmodule

// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
// Bit-serial WIDTH-bit adder: one FULL_ADDER cell plus a registered carry,
// processing one bit per clock LSB-first. Operands arrive on a valid/ready
// handshake, the result leaves on a second valid/ready handshake.
//
// Parameters:
//   WIDTH      operand/sum width, legal range WIDTH_MIN..WIDTH_MAX (2..32)
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   synchronous reset, active-low
//   in_valid   in   a/b/cin valid
//   in_ready   out  high only in IDLE
//   a, b       in   operands (sampled at the input handshake only)
//   cin        in   carry-in
//   sub        in   (only with SERIAL_ADDER_SUB_EN) 1 = compute a-b
//   out_valid  out  result valid (DONE)
//   out_ready  in   downstream accepts result
//   sum        out  a+b+cin mod 2^WIDTH, held until the next result completes
//   cout       out  carry-out of bit WIDTH-1
//   busy       out  high in RUN or DONE
//
// Optional feature macro: SERIAL_ADDER_SUB_EN (adds the sub input).
// -----------------------------------------------------------------------------
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_t           r_state;
    state_t           w_state_next;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-2:0] r_sum_sh;
    logic             r_carry;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;

    logic             w_s;
    logic             w_co;
    logic [WIDTH-1:0] w_sum_full;
    logic [WIDTH-1:0] w_b_load;
    logic             w_carry_load;

    // Subtraction is a + ~b + 1; cin is ignored in that mode.
`ifdef SERIAL_ADDER_SUB_EN
    assign w_b_load     = sub ? ~b : b;
    assign w_carry_load = sub ? 1'b1 : cin;
`else
    assign w_b_load     = b;
    assign w_carry_load = cin;
`endif

    FULL_ADDER u_fa (
        .A  (r_a_sh[0]),
        .B  (r_b_sh[0]),
        .Ci (r_carry),
        .S  (w_s),
        .Co (w_co)
    );

    // Partial sum with the current bit placed at the MSB. Only WIDTH-1 bits
    // are kept between edges; on the last bit this vector is the full sum.
    assign w_sum_full = {w_s, r_sum_sh};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= STATE_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        busy         = 1'b0;
        case (r_state)
            STATE_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_state_next = STATE_RUN;
            end
            STATE_RUN: begin
                busy = 1'b1;
                if (r_cnt == CNT_LAST) w_state_next = STATE_DONE;
            end
            STATE_DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) w_state_next = STATE_IDLE;
            end
            default: w_state_next = STATE_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_a_sh   <= '0;
            r_b_sh   <= '0;
            r_sum_sh <= '0;
            r_carry  <= 1'b0;
            r_sum    <= '0;
            r_cout   <= 1'b0;
        end else begin
            case (r_state)
                STATE_IDLE: begin
                    if (in_valid) begin
                        r_a_sh  <= a;
                        r_b_sh  <= w_b_load;
                        r_carry <= w_carry_load;
                        r_cnt   <= '0;
                    end
                end
                STATE_RUN: begin
                    r_sum_sh <= w_sum_full[WIDTH-1:1];
                    r_a_sh   <= r_a_sh >> 1;
                    r_b_sh   <= r_b_sh >> 1;
                    r_carry  <= w_co;
                    r_cnt    <= r_cnt + 1'b1;
                    // Output registers update only when a result completes,
                    // so sum/cout hold the previous result through a new RUN.
                    if (r_cnt == CNT_LAST) begin
                        r_sum  <= w_sum_full;
                        r_cout <= w_co;
                    end
                end
                default: ;
            endcase
        end
    end

    assign sum  = r_sum;
    assign cout = r_cout;

endmodule

// File: tb/tb_serial_adder.sv
module tb_serial_adder;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
`ifdef SERIAL_ADDER_SUB_EN
    logic             sub;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             busy;

    int tests = 0;
    int fails = 0;

    serial_adder #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef SERIAL_ADDER_SUB_EN
        .sub       (sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
        $display("[TB] check %s observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Waits for out_valid with a cycle budget; returns cycles spent.
    task automatic wait_valid(input int budget, output int cycles, output logic ok);
        cycles = 0;
        ok     = 1'b0;
        while (cycles < budget && !ok) begin
            tick();
            cycles++;
            if (out_valid) ok = 1'b1;
        end
    endtask

    // Back-to-back vectors
    logic [WIDTH-1:0] bb_a   [3] = '{8'h01, 8'h80, 8'h7F};
    logic [WIDTH-1:0] bb_b   [3] = '{8'h02, 8'h80, 8'h01};
    logic             bb_cin [3] = '{1'b0, 1'b0, 1'b1};
    logic [WIDTH-1:0] bb_sum [3] = '{8'h03, 8'h00, 8'h81};
    logic             bb_co  [3] = '{1'b0, 1'b1, 1'b0};

    initial begin
        int   cyc;
        logic ok;
        logic seen;
        int   n_acc, n_res, last_res, t;
        logic accepting;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
        sub       = 1'b0;
`endif
        tick();
        tick();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_sum",       32'(sum),       32'd0);
        check("rst_cout",      32'(cout),      32'd0);
        check("rst_busy",      32'(busy),      32'd0);
        rst_n = 1'b1;
        tick();
        check("rst_in_ready",  32'(in_ready),  32'd1);

        // 0x5A + 0x33 + 0: latency exactly WIDTH cycles
        a = 8'h5A; b = 8'h33; cin = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        a = 8'hFF; b = 8'hFF; cin = 1'b1;    // must be ignored
        check("op1_busy",     32'(busy),     32'd1);
        check("op1_in_ready", 32'(in_ready), 32'd0);
        repeat (7) tick();
        check("op1_valid_e7", 32'(out_valid), 32'd0);
        tick();
        check("op1_valid_e8", 32'(out_valid), 32'd1);
        check("op1_sum",      32'(sum),       32'h8D);
        check("op1_cout",     32'(cout),      32'd0);
        check("op1_ready_dn", 32'(in_ready),  32'd0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("op1_consumed", 32'(out_valid), 32'd0);
        check("op1_ready_up", 32'(in_ready),  32'd1);
        check("op1_idle",     32'(busy),      32'd0);
        check("op1_sum_hold", 32'(sum),       32'h8D);

        // 0xFF + 0x01 + 1 under backpressure
        a = 8'hFF; b = 8'h01; cin = 1'b1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        wait_valid(20, cyc, ok);
        check("op2_valid",   32'(ok),   32'd1);
        check("op2_latency", 32'(cyc),  32'd8);
        check("op2_sum",     32'(sum),  32'h01);
        check("op2_cout",    32'(cout), 32'd1);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            a = 8'(i * 17); b = 8'(i + 3); cin = i[0];
            tick();
            check("bp_valid",    32'(out_valid), 32'd1);
            check("bp_sum",      32'(sum),       32'h01);
            check("bp_cout",     32'(cout),      32'd1);
            check("bp_in_ready", 32'(in_ready),  32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp_consumed", 32'(out_valid), 32'd0);
        check("bp_ready_up", 32'(in_ready),  32'd1);
        tick();
        check("bp_no_queue", 32'(busy),      32'd0);

        // Reset in the middle of RUN aborts the operation
        a = 8'h0F; b = 8'h0F; cin = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
        check("mid_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        tick();
        tick();
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_sum",   32'(sum),       32'd0);
        check("mid_rst_cout",  32'(cout),      32'd0);
        check("mid_rst_busy",  32'(busy),      32'd0);
        rst_n = 1'b1;
        tick();
        check("mid_in_ready",  32'(in_ready),  32'd1);
        seen = 1'b0;
        repeat (12) begin
            tick();
            if (out_valid) seen = 1'b1;
        end
        check("mid_no_result", 32'(seen), 32'd0);
        check("mid_sum_zero",  32'(sum),  32'd0);

        // Back-to-back: in_valid held high, out_ready high
        out_ready = 1'b1;
        n_acc = 0; n_res = 0; last_res = 0; t = 0;
        a = bb_a[0]; b = bb_b[0]; cin = bb_cin[0]; in_valid = 1'b1;
        while (n_res < 3 && t < 100) begin
            accepting = in_ready && in_valid;
            tick();
            t++;
            if (accepting) begin
                n_acc++;
                if (n_acc < 3) begin
                    a = bb_a[n_acc]; b = bb_b[n_acc]; cin = bb_cin[n_acc];
                end else begin
                    in_valid = 1'b0;
                end
            end
            if (out_valid) begin
                check("bb_sum",  32'(sum),  32'(bb_sum[n_res]));
                check("bb_cout", 32'(cout), 32'(bb_co[n_res]));
                if (n_res > 0) check("bb_period", 32'(t - last_res), 32'(WIDTH + 2));
                last_res = t;
                n_res++;
            end
        end
        check("bb_results", 32'(n_res), 32'd3);
        in_valid = 1'b0;
        seen = 1'b0;
        repeat (12) begin
            tick();
            if (out_valid) seen = 1'b1;
        end
        check("bb_no_extra", 32'(seen), 32'd0);
        out_ready = 1'b0;

`ifdef SERIAL_ADDER_SUB_EN
        // 0x10 - 0x20 = 0xF0 with borrow (cout=0); cin must be ignored
        a = 8'h10; b = 8'h20; cin = 1'b0; sub = 1'b1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0; sub = 1'b0;
        wait_valid(20, cyc, ok);
        check("sub1_valid", 32'(ok),   32'd1);
        check("sub1_sum",   32'(sum),  32'hF0);
        check("sub1_cout",  32'(cout), 32'd0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        // 0x20 - 0x10 = 0x10, no borrow (cout=1)
        a = 8'h20; b = 8'h10; cin = 1'b0; sub = 1'b1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0; sub = 1'b0;
        wait_valid(20, cyc, ok);
        check("sub2_valid", 32'(ok),   32'd1);
        check("sub2_sum",   32'(sum),  32'h10);
        check("sub2_cout",  32'(cout), 32'd1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        // sub=0 behaves as add: 0x20 + 0x10 + 1 = 0x31
        a = 8'h20; b = 8'h10; cin = 1'b1; sub = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        wait_valid(20, cyc, ok);
        check("sub0_valid", 32'(ok),   32'd1);
        check("sub0_sum",   32'(sum),  32'h31);
        check("sub0_cout",  32'(cout), 32'd0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
